// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency RAM between the fetch (I) and load/store (D) ports.
// Build option ARB_ROUND_ROBIN_EN: round-robin on conflict instead of fixed D priority with anti-starvation.
module mem_port_arbiter #(
    parameter int AWIDTH     = 14,
    parameter int DWIDTH     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AWIDTH-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DWIDTH-1:0] i_rdata,
    input  logic              d_req,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [3:0]        d_we,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic [1:0]        o_rsp_owner
);

    // Handshake: a requester holds req and its address/data until it sees gnt in the same
    // cycle; a granted read returns exactly one cycle later on rvalid, with no buffering.
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D    = 2'd2
    } rsp_owner_t;

    rsp_owner_t r_rsp_owner;
    rsp_owner_t w_rsp_owner_nxt;
    logic       w_conflict;
    logic       w_i_wins;

    assign w_conflict = i_req & d_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_last_i;

    // The port that lost the previous conflict wins the next one.
    assign w_i_wins = ~r_rr_last_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last_i <= 1'b1;
        end else if (w_conflict) begin
            r_rr_last_i <= w_i_wins;
        end
    end
`else
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] r_starve_cnt;

    assign w_i_wins = (r_starve_cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (i_req & ~i_gnt) begin
            if (r_starve_cnt != CW'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + CW'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`endif

    assign i_gnt = ~rst & i_req & (~d_req | w_i_wins);
    assign d_gnt = ~rst & d_req & (~i_req | ~w_i_wins);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_owner <= RSP_NONE;
        end else begin
            r_rsp_owner <= w_rsp_owner_nxt;
        end
    end

    // Stores produce no response, so only reads move the tracker off NONE.
    always_comb begin
        w_rsp_owner_nxt = RSP_NONE;
        if (i_gnt) begin
            w_rsp_owner_nxt = RSP_I;
        end else if (d_gnt && (d_we == 4'b0000)) begin
            w_rsp_owner_nxt = RSP_D;
        end
    end

    // Gating with rst drops a read that was granted in the cycle before reset.
    assign i_rvalid    = ~rst & (r_rsp_owner == RSP_I);
    assign d_rvalid    = ~rst & (r_rsp_owner == RSP_D);
    assign i_rdata     = mem_dout;
    assign d_rdata     = mem_dout;
    assign o_rsp_owner = r_rsp_owner;

    assign mem_en   = i_gnt | d_gnt;
    assign mem_we   = d_gnt ? d_we : 4'b0000;
    assign mem_addr = i_gnt ? i_addr : d_addr;
    assign mem_din  = d_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, vector table, hand sequences and a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req;
    logic [AW-1:0] i_addr, d_addr;
    logic [3:0]    d_we;
    logic [DW-1:0] d_wdata;
    logic          i_gnt, d_gnt, i_rvalid, d_rvalid;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [1:0]    o_rsp_owner;

    int n_total = 0;
    int n_bad   = 0;

    mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .o_rsp_owner(o_rsp_owner)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // single-port synchronous RAM, read data one cycle after enable
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end
            mem_dout <= ram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] init_word(input int a);
        return (32'(a) * 32'h9E3779B9) ^ 32'h1234_5678;
    endfunction

    // reference model state
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            m_pend_i, m_pend_d;
    logic [DW-1:0] m_pend_data;
`ifdef ARB_ROUND_ROBIN_EN
    bit            m_rr_i_turn;
`else
    int            m_denied;
`endif

    typedef struct {
        bit            gi;
        bit            gd;
        bit            irv;
        bit            drv;
        logic [DW-1:0] ird;
        logic [DW-1:0] drd;
    } obs_t;

    typedef struct {
        bit            ir;
        logic [AW-1:0] ia;
        bit            dr;
        logic [AW-1:0] da;
        logic [3:0]    dwe;
        logic [DW-1:0] dwd;
        bit            egi;
        bit            egd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // driver: one cycle, called just after a rising edge; returns just after the next one
    task automatic step(input bit r, input bit ir, input logic [AW-1:0] ia,
                        input bit dr, input logic [AW-1:0] da,
                        input logic [3:0] dwe, input logic [DW-1:0] dwd, output obs_t o);
        bit ei, ed;
        rst = r; i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_we = dwe; d_wdata = dwd;
        ei = 1'b0;
        ed = 1'b0;
        if (!r) begin
            if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
                ei = m_rr_i_turn;
`else
                ei = (m_denied >= STARVE_MAX);
`endif
                ed = !ei;
            end else begin
                ei = ir;
                ed = dr;
            end
        end
        @(negedge clk);
        o.gi = i_gnt; o.gd = d_gnt; o.irv = i_rvalid; o.drv = d_rvalid;
        o.ird = i_rdata; o.drd = d_rdata;
        chk("i_gnt", i_gnt, ei);
        chk("d_gnt", d_gnt, ed);
        chk("i_rvalid", i_rvalid, m_pend_i && !r);
        chk("d_rvalid", d_rvalid, m_pend_d && !r);
        if (m_pend_i && !r) chk("i_rdata", i_rdata, m_pend_data);
        if (m_pend_d && !r) chk("d_rdata", d_rdata, m_pend_data);
        chk("mem_en", mem_en, ei | ed);
        chk("mem_we", mem_we, ed ? dwe : 4'b0000);
        if (ei) chk("mem_addr_i", mem_addr, ia);
        else if (ed) chk("mem_addr_d", mem_addr, da);
        if (ed && dwe != 4'b0000) chk("mem_din", mem_din, dwd);
        if (o_rsp_owner == 2'd3) chk("rsp_owner_enc", o_rsp_owner, 2'd0);

        // advance the model by one cycle
        m_pend_i = 1'b0;
        m_pend_d = 1'b0;
        if (r) begin
`ifdef ARB_ROUND_ROBIN_EN
            m_rr_i_turn = 1'b0;
`else
            m_denied = 0;
`endif
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            if (ir && dr) m_rr_i_turn = !ei;
`else
            if (ir && !ei) m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
            else m_denied = 0;
`endif
            if (ei) begin
                m_pend_i = 1'b1;
                m_pend_data = shadow[ia];
            end else if (ed) begin
                if (dwe == 4'b0000) begin
                    m_pend_d = 1'b1;
                    m_pend_data = shadow[da];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (dwe[b]) shadow[da][8*b +: 8] = dwd[8*b +: 8];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r, output obs_t o);
        step(r, 1'b0, '0, 1'b0, '0, 4'b0000, '0, o);
    endtask

    // test sequence
    vec_t tbl[$];
    obs_t o;
    bit   hold_i, hold_d, r, ir, dr;
    logic [AW-1:0] ia, da;
    logic [3:0]    dwe;
    logic [DW-1:0] dwd;

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            ram[a]    = init_word(a);
            shadow[a] = init_word(a);
        end
        m_pend_i = 1'b0;
        m_pend_d = 1'b0;
        m_pend_data = '0;
`ifdef ARB_ROUND_ROBIN_EN
        m_rr_i_turn = 1'b0;
`else
        m_denied = 0;
`endif
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
        @(posedge clk);
        #1;

        // grants must stay low in reset even with both requests up
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 14'h001, 1'b1, 14'h002, 4'b0000, '0, o);
            chk("gnt_in_rst", {o.gi, o.gd}, 2'b00);
        end
        idle(1'b0, o);
        chk("reset_rvalid", {o.irv, o.drv}, 2'b00);

`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 6; k++)
            tbl.push_back('{1'b1, 14'h004, 1'b1, 14'(14'h100 + k), 4'b0000, '0, k[0], !k[0]});
        tbl.push_back('{1'b0, 14'h0, 1'b0, 14'h0, 4'b0000, '0, 1'b0, 1'b0});
`else
        // I-only burst
        for (int k = 0; k < 3; k++)
            tbl.push_back('{1'b1, 14'(14'h010 + k), 1'b0, 14'h0, 4'b0000, '0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 14'h0, 1'b0, 14'h0, 4'b0000, '0, 1'b0, 1'b0});
        // conflict: D first, then I
        tbl.push_back('{1'b1, 14'h004, 1'b1, 14'h100, 4'b0000, '0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 14'h004, 1'b0, 14'h0, 4'b0000, '0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 14'h0, 1'b0, 14'h0, 4'b0000, '0, 1'b0, 1'b0});
        // starvation: I forced through on the 5th conflict cycle
        for (int k = 0; k < 4; k++)
            tbl.push_back('{1'b1, 14'h040, 1'b1, 14'(14'h200 + k), 4'b0000, '0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 14'h040, 1'b1, 14'h204, 4'b0000, '0, 1'b1, 1'b0});
        for (int k = 5; k < 10; k++)
            tbl.push_back('{1'b0, 14'h0, 1'b1, 14'(14'h200 + k), 4'b0000, '0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 14'h0, 1'b0, 14'h0, 4'b0000, '0, 1'b0, 1'b0});
`endif
        foreach (tbl[n]) begin
            step(1'b0, tbl[n].ir, tbl[n].ia, tbl[n].dr, tbl[n].da, tbl[n].dwe, tbl[n].dwd, o);
            chk("tbl_i_gnt", o.gi, tbl[n].egi);
            chk("tbl_d_gnt", o.gd, tbl[n].egd);
        end

        // store, partial store, load back the merged word
        step(1'b0, 1'b0, '0, 1'b1, 14'h020, 4'b1111, 32'h1111_1111, o);
        step(1'b0, 1'b0, '0, 1'b1, 14'h020, 4'b0011, 32'hDEAD_BEEF, o);
        chk("store_no_rvalid", o.drv, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 14'h020, 4'b0000, '0, o);
        chk("store2_no_rvalid", o.drv, 1'b0);
        idle(1'b0, o);
        chk("load_rvalid", o.drv, 1'b1);
        chk("load_data", o.drd, 32'h1111_BEEF);

        // reset right after a granted fetch drops the response
        step(1'b0, 1'b1, 14'h030, 1'b0, '0, 4'b0000, '0, o);
        chk("pre_rst_gnt", o.gi, 1'b1);
        step(1'b1, 1'b1, 14'h031, 1'b1, 14'h032, 4'b0000, '0, o);
        chk("rst_i_gnt", o.gi, 1'b0);
        chk("rst_i_rvalid", o.irv, 1'b0);
        idle(1'b0, o);
        chk("post_rst_rvalid", {o.irv, o.drv}, 2'b00);

        // randomized traffic; unaccepted requests are held as the handshake requires
        hold_i = 1'b0; hold_d = 1'b0;
        ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dwe = '0; dwd = '0;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 49) == 0);
            if (!hold_i) begin
                ir = 1'($urandom_range(0, 1));
                ia = 14'($urandom_range(0, 63));
            end
            if (!hold_d) begin
                dr = 1'($urandom_range(0, 1));
                da = 14'($urandom_range(0, 63));
                dwe = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                dwd = $urandom;
            end
            step(r, ir, ia, dr, da, dwe, dwd, o);
            hold_i = ir && !o.gi && !r;
            hold_d = dr && !o.gd && !r;
        end
        idle(1'b0, o);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
